field_unpack: RTL and testbench

FIELD_UNPACK -- requirements
Module: field_unpack

---
 rtl/field_unpack.sv | 228 ++++++++++++++++++++++
 tb/tb_field_unpack.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/field_unpack.sv
// ---------------------------------------------------------------------------
// field_unpack
//
// Serial frame deframer and field decoder. A frame is a 5-bit SYNC_PAT header
// followed by 27 payload bits, MSB first. Define PAR_CHECK_EN to accept a
// trailing even-parity bit after the payload. When that macro is left
// undefined, frames are 32 bits long and out_perr is always 0.
//
// Parameters
//   SYNC_PAT  - 5-bit frame header pattern
//   MAX_MISS  - consecutive bad headers tolerated before lock is dropped
//
// Ports
//   sysclk     in   single clock, rising edge
//   reset      in   asynchronous, active-high reset
//   din        in   serial frame data, MSB first
//   din_en     in   bit strobe; din is sampled only when high
//   out_ready  in   sink ready for the decoded word
//   out_valid  out  decoded word available
//   enf        out  payload bits [26:19]
//   load       out  payload bits [18:11]
//   qtd        out  payload bits [10:7]
//   base       out  payload bits [6:0]
//   locked     out  frame alignment established
//   overrun    out  one-cycle pulse when a completed word is dropped
//   out_perr   out  parity error flag, qualified by out_valid
// ---------------------------------------------------------------------------
module field_unpack #(
  parameter logic [4:0] SYNC_PAT = 5'b11001,
  parameter int         MAX_MISS = 3
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       din,
  input  logic       din_en,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] enf,
  output logic [7:0] load,
  output logic [3:0] qtd,
  output logic [6:0] base,
  output logic       locked,
  output logic       overrun,
  output logic       out_perr
);

`ifdef PAR_CHECK_EN
  localparam int PLEN = 28;
`else
  localparam int PLEN = 27;
`endif
  localparam int             MW         = $clog2(MAX_MISS + 1);
  localparam logic [MW-1:0]  MISS_LIMIT = MW'(MAX_MISS);
  localparam logic [4:0]     PAY_LAST   = 5'(PLEN - 1);
  localparam logic [4:0]     HDR_LAST   = 5'd4;

  typedef enum logic [1:0] {
    HUNT,
    PAYLOAD,
    HDR_CHECK
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      win_q, win_d;
  logic [PLEN-2:0] pay_q, pay_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [MW-1:0]   miss_q, miss_d;
  logic            valid_q, valid_d;
  logic [7:0]      enf_q, enf_d;
  logic [7:0]      load_q, load_d;
  logic [3:0]      qtd_q, qtd_d;
  logic [6:0]      base_q, base_d;
  logic            perr_q, perr_d;
  logic            locked_q, locked_d;
  logic            overrun_q, overrun_d;

  logic [4:0]      win_next;
  logic [PLEN-1:0] pay_full;
  logic [26:0]     word;
  logic            perr_calc;
  logic            word_done;
  logic            hdr_match;
  logic [MW-1:0]   miss_inc;

  // The header window always holds the last five strobed bits. HUNT searches
  // it on every strobe, and HDR_CHECK reads it once five header bits are in.
  // pay_q keeps one bit fewer than the frame body because the final bit is
  // taken straight from din in the cycle the word is handed off.
  always_comb begin
    win_next = {win_q[3:0], din};
    pay_full = {pay_q, din};
    hdr_match = (win_next == SYNC_PAT);
    miss_inc = miss_q + 1'b1;
`ifdef PAR_CHECK_EN
    word      = pay_full[27:1];
    perr_calc = ^pay_full;
`else
    word      = pay_full;
    perr_calc = 1'b0;
`endif
  end

  // Next-state logic for framing. Nothing moves unless din_en is high.
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    pay_d     = pay_q;
    cnt_d     = cnt_q;
    miss_d    = miss_q;
    locked_d  = locked_q;
    word_done = 1'b0;
    if (din_en) begin
      win_d = win_next;
      case (state_q)
        HUNT: begin
          if (hdr_match) begin
            state_d  = PAYLOAD;
            locked_d = 1'b1;
            miss_d   = '0;
            cnt_d    = '0;
          end
        end
        PAYLOAD: begin
          pay_d = pay_full[PLEN-2:0];
          if (cnt_q == PAY_LAST) begin
            cnt_d     = '0;
            state_d   = HDR_CHECK;
            word_done = 1'b1;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        HDR_CHECK: begin
          if (cnt_q == HDR_LAST) begin
            cnt_d = '0;
            if (hdr_match) begin
              state_d = PAYLOAD;
              miss_d  = '0;
            end else begin
              // The payload behind a bad header is still decoded while the
              // miss budget lasts. Lock is dropped only when the budget runs out.
              miss_d = miss_inc;
              if (miss_inc < MISS_LIMIT) begin
                state_d = PAYLOAD;
              end else begin
                state_d  = HUNT;
                locked_d = 1'b0;
              end
            end
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // Output hand-off. A finished word loads the output registers when the
  // slot is empty or is being drained in the same cycle. Otherwise the word
  // is dropped and overrun is flagged. Losing lock never touches this slot.
  always_comb begin
    valid_d   = valid_q;
    enf_d     = enf_q;
    load_d    = load_q;
    qtd_d     = qtd_q;
    base_d    = base_q;
    perr_d    = perr_q;
    overrun_d = 1'b0;
    if (word_done) begin
      if (!valid_q || out_ready) begin
        valid_d = 1'b1;
        enf_d   = word[26:19];
        load_d  = word[18:11];
        qtd_d   = word[10:7];
        base_d  = word[6:0];
        perr_d  = perr_calc;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q   <= HUNT;
      win_q     <= '0;
      pay_q     <= '0;
      cnt_q     <= '0;
      miss_q    <= '0;
      valid_q   <= 1'b0;
      enf_q     <= '0;
      load_q    <= '0;
      qtd_q     <= '0;
      base_q    <= '0;
      perr_q    <= 1'b0;
      locked_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      pay_q     <= pay_d;
      cnt_q     <= cnt_d;
      miss_q    <= miss_d;
      valid_q   <= valid_d;
      enf_q     <= enf_d;
      load_q    <= load_d;
      qtd_q     <= qtd_d;
      base_q    <= base_d;
      perr_q    <= perr_d;
      locked_q  <= locked_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_valid = valid_q;
  assign enf       = enf_q;
  assign load      = load_q;
  assign qtd       = qtd_q;
  assign base      = base_q;
  assign locked    = locked_q;
  assign overrun   = overrun_q;
  assign out_perr  = perr_q;

endmodule

// File: tb/tb_field_unpack.sv
// ---------------------------------------------------------------------------
// tb_field_unpack
//
// Testbench for field_unpack. Stimulus is generated one frame at a time. A
// frame-level model decides whether each frame is locked onto and whether its
// payload is delivered, and annotates the bit strobes with those decisions. A
// cycle model turns the annotations into the expected out_valid, locked and
// overrun values, and pushes delivered words into a queue. A monitor checks
// the DUT against that queue and those flags on every falling edge.
// Honours PAR_CHECK_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_field_unpack;

  localparam logic [4:0] SYNC = 5'b11001;
  localparam int         MAXM = 3;
`ifdef PAR_CHECK_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif

  logic       sysclk = 1'b0;
  logic       reset = 1'b0;
  logic       din = 1'b0;
  logic       din_en = 1'b0;
  logic       out_ready = 1'b1;
  logic       out_valid;
  logic [7:0] enf;
  logic [7:0] load;
  logic [3:0] qtd;
  logic [6:0] base;
  logic       locked;
  logic       overrun;
  logic       out_perr;

  int checks = 0;
  int errors = 0;

  // Expected words are stored as {perr, payload[26:0]}.
  logic [27:0] expq[$];
  bit          exp_valid = 1'b0;
  bit          exp_locked = 1'b0;
  bit          exp_ovr = 1'b0;
  bit          mon_en = 1'b0;

  // Annotations attached to the strobe currently on din.
  bit          ann_handoff = 1'b0;
  bit          ann_lock_upd = 1'b0;
  bit          ann_lock_val = 1'b0;
  logic [27:0] ann_word = '0;

  // Frame-level lock model.
  bit m_locked = 1'b0;
  int m_miss = 0;

  bit rdy_random = 1'b0;
  bit rdy_fixed = 1'b1;

  logic [27:0] mon_w;

  field_unpack dut (
    .sysclk   (sysclk),
    .reset    (reset),
    .din      (din),
    .din_en   (din_en),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .enf      (enf),
    .load     (load),
    .qtd      (qtd),
    .base     (base),
    .locked   (locked),
    .overrun  (overrun),
    .out_perr (out_perr)
  );

  always #5 sysclk = ~sysclk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // The sink changes out_ready shortly after each rising edge.
  always @(posedge sysclk) begin
    #2;
    out_ready = rdy_random ? 1'($urandom) : rdy_fixed;
  end

  // Cycle model. A word leaves the slot when out_valid and out_ready are both
  // high. A new word enters when the slot is free or is draining that cycle.
  // Otherwise the new word is lost and overrun is expected for one cycle.
  always @(posedge sysclk or posedge reset) begin
    if (reset) begin
      exp_valid  = 1'b0;
      exp_locked = 1'b0;
      exp_ovr    = 1'b0;
      expq.delete();
    end else begin
      exp_ovr = 1'b0;
      if (din_en && ann_lock_upd) exp_locked = ann_lock_val;
      if (din_en && ann_handoff) begin
        if (!exp_valid || out_ready) begin
          expq.push_back(ann_word);
          exp_valid = 1'b1;
        end else begin
          exp_ovr = 1'b1;
        end
      end else if (exp_valid && out_ready) begin
        exp_valid = 1'b0;
      end
    end
  end

  // Monitor: compares flags every cycle and the presented word against the
  // head of the queue. It pops the head when the word is taken.
  always @(negedge sysclk) begin
    if (mon_en) begin
      checkOutput("out_valid", 32'(out_valid), 32'(exp_valid));
      checkOutput("locked", 32'(locked), 32'(exp_locked));
      checkOutput("overrun", 32'(overrun), 32'(exp_ovr));
      if (out_valid === 1'b1) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_word: got enf=%0h load=%0h qtd=%0h base=%0h, required no word", enf, load, qtd, base);
        end else begin
          mon_w = expq[0];
          checkOutput("enf", 32'(enf), 32'(mon_w[26:19]));
          checkOutput("load", 32'(load), 32'(mon_w[18:11]));
          checkOutput("qtd", 32'(qtd), 32'(mon_w[10:7]));
          checkOutput("base", 32'(base), 32'(mon_w[6:0]));
          checkOutput("out_perr", 32'(out_perr), 32'(mon_w[27]));
          if (out_ready) void'(expq.pop_front());
        end
      end
    end
  end

  task automatic idleCycle();
    @(posedge sysclk);
    #2;
    din_en       = 1'b0;
    din          = 1'($urandom);
    ann_handoff  = 1'b0;
    ann_lock_upd = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) idleCycle();
  endtask

  task automatic strobe(input bit b, input bit lupd, input bit lval, input bit ho, input logic [27:0] w);
    @(posedge sysclk);
    #2;
    din          = b;
    din_en       = 1'b1;
    ann_lock_upd = lupd;
    ann_lock_val = lval;
    ann_handoff  = ho;
    ann_word     = w;
  endtask

  task automatic doReset();
    @(posedge sysclk);
    #2;
    din_en       = 1'b0;
    ann_handoff  = 1'b0;
    ann_lock_upd = 1'b0;
    reset        = 1'b1;
    m_locked     = 1'b0;
    m_miss       = 0;
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_enf", 32'(enf), 32'd0);
    checkOutput("rst_load", 32'(load), 32'd0);
    checkOutput("rst_qtd", 32'(qtd), 32'd0);
    checkOutput("rst_base", 32'(base), 32'd0);
    checkOutput("rst_locked", 32'(locked), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);
    checkOutput("rst_out_perr", 32'(out_perr), 32'd0);
    @(posedge sysclk);
    #2;
    reset  = 1'b0;
    mon_en = 1'b1;
  endtask

  // Sends one frame. gap_mode: 0 = strobe every cycle, 1 = one idle cycle after
  // every strobe, 2 = random idle gaps. stop_after >= 0 ends the frame early.
  task automatic applyStimulus(input logic [4:0] hdr, input logic [26:0] pay, input bit bad_par,
                               input int gap_mode, input int stop_after);
    bit          deliver;
    bit          lupd;
    bit          lval;
    logic        par;
    logic        perr_exp;
    logic [27:0] w;
    int          nbits;
    bit          b;
    deliver = 1'b0;
    lupd    = 1'b0;
    lval    = m_locked;
    if (!m_locked) begin
      if (hdr == SYNC) begin
        lupd = 1'b1; lval = 1'b1; m_locked = 1'b1; m_miss = 0; deliver = 1'b1;
      end
    end else if (hdr == SYNC) begin
      m_miss = 0; deliver = 1'b1;
    end else begin
      m_miss++;
      if (m_miss >= MAXM) begin
        lupd = 1'b1; lval = 1'b0; m_locked = 1'b0;
      end else begin
        deliver = 1'b1;
      end
    end
    // Even parity: the count of ones across payload and parity bit is even.
    par      = (^pay) ^ bad_par;
    perr_exp = (PBITS == 1) && (^{pay, par});
    w        = {perr_exp, pay};
    nbits    = 32 + PBITS;
    for (int i = 0; i < nbits; i++) begin
      if (stop_after >= 0 && i >= stop_after) break;
      if (gap_mode == 2) idleCycles($urandom_range(0, 2));
      if (i < 5) b = hdr[4-i];
      else if (i < 32) b = pay[31-i];
      else b = par;
      strobe(b, (i == 4) && lupd, lval, (i == nbits - 1) && deliver, w);
      if (gap_mode == 1) idleCycle();
    end
  endtask

  function automatic logic [4:0] badHeader();
    logic [4:0] h;
    h = 5'($urandom);
    if (h == SYNC) h = h ^ 5'b00001;
    return h;
  endfunction

  initial begin
    logic [4:0] hdr;
    doReset();

    $display("[TB] single frame, known fields");
    rdy_fixed = 1'b1;
    applyStimulus(SYNC, {8'hA5, 8'h3C, 4'h9, 7'h55}, 1'b0, 0, -1);
    idleCycles(4);

    $display("[TB] three frames, strobe every other cycle");
    for (int f = 0; f < 3; f++) applyStimulus(SYNC, 27'($urandom), 1'b0, 1, -1);
    idleCycles(4);

    $display("[TB] sink stalled across two frames");
    rdy_fixed = 1'b0;
    idleCycles(2);
    applyStimulus(SYNC, 27'($urandom), 1'b0, 0, -1);
    applyStimulus(SYNC, 27'($urandom), 1'b0, 0, -1);
    idleCycles(3);
    rdy_fixed = 1'b1;
    idleCycles(4);

    $display("[TB] loss of lock after repeated bad headers");
    applyStimulus(SYNC, 27'($urandom), 1'b0, 0, -1);
    applyStimulus(5'b10101, 27'($urandom), 1'b0, 0, -1);
    applyStimulus(5'b10101, 27'($urandom), 1'b0, 0, -1);
    applyStimulus(5'b10101, 27'd0, 1'b0, 0, -1);
    idleCycles(3);
    applyStimulus(SYNC, 27'($urandom), 1'b0, 0, -1);
    applyStimulus(SYNC, 27'($urandom), 1'b0, 0, -1);
    idleCycles(4);

    $display("[TB] reset in the middle of a frame");
    applyStimulus(SYNC, 27'($urandom), 1'b0, 0, 5 + 13);
    doReset();
    idleCycles(2);
    applyStimulus(SYNC, 27'($urandom), 1'b0, 0, -1);
    idleCycles(4);

    $display("[TB] parity good and bad");
    applyStimulus(SYNC, 27'($urandom), 1'b1, 0, -1);
    applyStimulus(SYNC, 27'($urandom), 1'b0, 0, -1);
    idleCycles(4);

    $display("[TB] random frames, gaps and sink stalls");
    rdy_random = 1'b1;
    for (int f = 0; f < 40; f++) begin
      hdr = SYNC;
      if ($urandom_range(0, 3) == 0 && m_miss < MAXM - 1) hdr = badHeader();
      applyStimulus(hdr, 27'($urandom), 1'($urandom), $urandom_range(0, 2), -1);
    end
    rdy_random = 1'b0;
    rdy_fixed  = 1'b1;
    idleCycles(10);
    checkOutput("drain_empty", 32'(expq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
